// File: rtl/fifo_rr_arbiter_pkg.sv
// rtl/fifo_rr_arbiter_pkg.sv - shared sizing defaults for the round-robin arbiter and its FIFO
package fifo_rr_arbiter_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_DEPTH = 8;

    // Pointer width that stays legal for a single producer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rtl/fifo_rr_arbiter_rr_pick.sv - combinational round-robin pick, first request at or after ptr
module rr_pick
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [NREQ-1:0]   pick_rot;
    logic [2*NREQ-1:0] pick_dbl;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign req_dbl  = {req, req} >> ptr;
    assign req_rot  = req_dbl[NREQ-1:0];
    assign pick_rot = req_rot & (-req_rot);
    assign pick_dbl = {pick_rot, pick_rot} << ptr;
    assign grant    = enable ? pick_dbl[2*NREQ-1:NREQ] : '0;

endmodule

// File: rtl/shift_register.sv
// rtl/shift_register.sv - shift-register FIFO; head at entry 0, caller never overflows or underflows it
module shift_register
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNTWID = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  nxt [DEPTH];
    logic [CNTWID-1:0] count;
    logic [CNTWID-1:0] wr_idx;

    // On a simultaneous pop the tail moves down one slot before the write lands.
    assign wr_idx = pop ? count - CNTWID'(1) : count;
    assign head   = mem[0];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = mem[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                nxt[i] = mem[i + 1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_idx == CNTWID'(i))) begin
                nxt[i] = push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem <= nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count + CNTWID'(push) - CNTWID'(pop);
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin arbiter feeding a shift-register FIFO, with shadow occupancy
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREQ   = DEF_NREQ,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNTWID = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       grant,
    input  logic                  pop_req,
    output logic                  fifo_push,
    output logic [WIDTH-1:0]      fifo_data,
    output logic                  fifo_pop,
    output logic [CNTWID-1:0]     occupancy,
    output logic [WIDTH-1:0]      pop_data
);

    localparam int PW = ptr_width(NREQ);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    sel;
    logic [WIDTH-1:0] sel_data;
    logic [CNTWID:0]  occ_next;
    logic             can_grant;
    logic             xfer;

    assign fifo_pop  = rst & pop_req & (occupancy != '0);
    // The push already in flight counts as occupied; a same-cycle pop frees a slot.
    assign occ_next  = {1'b0, occupancy} + {{CNTWID{1'b0}}, fifo_push} - {{CNTWID{1'b0}}, fifo_pop};
    assign can_grant = rst & (occ_next < (CNTWID+1)'(DEPTH));

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .enable (can_grant),
        .grant  (grant)
    );

    always_comb begin
        sel      = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel      = PW'(k);
                sel_data = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(grant & req);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= '0;
            fifo_push <= 1'b0;
            fifo_data <= '0;
            occupancy <= '0;
        end else begin
            fifo_push <= xfer;
            if (xfer) begin
                fifo_data <= sel_data;
                ptr       <= (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);
            end
            if (fifo_push && !fifo_pop) begin
                occupancy <= occupancy + CNTWID'(1);
            end else if (!fifo_push && fifo_pop) begin
                occupancy <= occupancy - CNTWID'(1);
            end
        end
    end

    shift_register #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .CNTWID (CNTWID)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_data),
        .pop       (fifo_pop),
        .head      (pop_data)
    );

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - self-checking bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;

    localparam int WIDTH  = 8;
    localparam int NREQ   = 4;
    localparam int DEPTH  = 8;
    localparam int CNTWID = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       grant;
    logic                  pop_req;
    logic                  fifo_push;
    logic [WIDTH-1:0]      fifo_data;
    logic                  fifo_pop;
    logic [CNTWID-1:0]     occupancy;
    logic [WIDTH-1:0]      pop_data;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(
        .WIDTH  (WIDTH),
        .NREQ   (NREQ),
        .DEPTH  (DEPTH),
        .CNTWID (CNTWID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .pop_req   (pop_req),
        .fifo_push (fifo_push),
        .fifo_data (fifo_data),
        .fifo_pop  (fifo_pop),
        .occupancy (occupancy),
        .pop_data  (pop_data)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of stored entries, one in-flight push, round-robin pointer.
    int mq[$];
    bit m_pend;
    int m_pend_d;
    int m_ptr;

    logic [3:0] s_grant;
    logic       s_pop;
    logic       s_push;
    logic [3:0] s_occ;
    logic [7:0] s_pdata;

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic       pr;
        logic [3:0] g;
        logic       fp;
        logic       push;
        logic [3:0] occ;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend   = 1'b0;
        m_pend_d = 0;
        m_ptr    = 0;
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] rd, input logic pr);
        int  k;
        int  occ_n;
        bit  ep;
        logic [3:0] eg;
        rst      = r;
        req      = rq;
        req_data = rd;
        pop_req  = pr;
        #2;
        s_grant = grant;
        s_pop   = fifo_pop;
        s_push  = fifo_push;
        s_occ   = occupancy;
        s_pdata = pop_data;
        ep    = r && pr && (mq.size() > 0);
        occ_n = mq.size() + int'(m_pend) - int'(ep);
        k     = -1;
        if (r && occ_n < DEPTH) begin
            for (int i = 0; i < NREQ; i++) begin
                int j;
                j = (m_ptr + i) % NREQ;
                if (k < 0 && rq[j]) k = j;
            end
        end
        eg = (k >= 0) ? 4'(1 << k) : 4'h0;
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_fifo_pop", 32'(fifo_pop), 32'(ep));
        chk("model_fifo_push", 32'(fifo_push), 32'(m_pend));
        chk("model_occupancy", 32'(occupancy), 32'(mq.size()));
        if (m_pend) chk("model_fifo_data", 32'(fifo_data), 32'(m_pend_d));
        if (ep) chk("model_pop_data", 32'(pop_data), 32'(mq[0]));
        @(posedge clk);
        #1;
        if (!r) begin
            model_reset();
        end else begin
            if (ep) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_pend_d);
            m_pend = (k >= 0);
            if (k >= 0) begin
                m_pend_d = (rd >> (WIDTH * k)) & 32'hff;
                m_ptr    = (k + 1) % NREQ;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_d;
        rst = 1'b0; req = '0; req_data = '0; pop_req = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset hold, fairness rotation, then draining to empty.
        tbl[0]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b0, 1'b1, 4'd0};
        tbl[5]  = '{1'b1, 4'hF, 1'b1, 4'h4, 1'b1, 1'b1, 4'd1};
        tbl[6]  = '{1'b1, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1, 4'd1};
        tbl[7]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1, 4'd1};
        tbl[8]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 4'd1};
        tbl[9]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 4'd1};
        tbl[10] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'd0};
        tbl[11] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'd0};
        for (int v = 0; v < 12; v++) begin
            step(tbl[v].r, tbl[v].rq, 32'h44332211, tbl[v].pr);
            chk($sformatf("vec%0d_grant", v), 32'(s_grant), 32'(tbl[v].g));
            chk($sformatf("vec%0d_fifo_pop", v), 32'(s_pop), 32'(tbl[v].fp));
            chk($sformatf("vec%0d_fifo_push", v), 32'(s_push), 32'(tbl[v].push));
            chk($sformatf("vec%0d_occupancy", v), 32'(s_occ), 32'(tbl[v].occ));
        end

        // Fill from producer 0 with data 1..8, then stall.
        for (int c = 0; c < 3; c++) step(1'b0, 4'h0, 32'h0, 1'b0);
        for (int c = 0; c < 12; c++) step(1'b1, 4'b0001, 32'(c + 1), 1'b0);
        step(1'b1, 4'b0001, 32'h0, 1'b0);
        chk("fill_occupancy", 32'(s_occ), 32'd8);
        chk("fill_grant_zero", 32'(s_grant), 32'h0);

        // Full FIFO with a pop frees space for a same-cycle grant.
        step(1'b1, 4'b0100, 32'h00AA0000, 1'b1);
        chk("full_pop_grant", 32'(s_grant), 32'h4);
        chk("full_pop_strobe", 32'(s_pop), 32'h1);
        chk("full_pop_occ", 32'(s_occ), 32'd8);
        chk("full_pop_data", 32'(s_pdata), 32'h01);
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 7) ? i + 2 : 32'hAA;
            step(1'b1, 4'h0, 32'h0, 1'b1);
            chk($sformatf("drain%0d_data", i), 32'(s_pdata), 32'(exp_d));
            chk($sformatf("drain%0d_pop", i), 32'(s_pop), 32'h1);
        end
        step(1'b1, 4'h0, 32'h0, 1'b1);
        chk("empty_pop_strobe", 32'(s_pop), 32'h0);
        chk("empty_pop_occ", 32'(s_occ), 32'd0);

        // Reset right after a transfer discards it and restarts the pointer.
        step(1'b1, 4'b0100, 32'h00BB0000, 1'b0);
        chk("mid_xfer_grant", 32'(s_grant), 32'h4);
        step(1'b0, 4'hF, 32'h0, 1'b1);
        chk("mid_rst_grant", 32'(s_grant), 32'h0);
        step(1'b1, 4'hF, 32'h44332211, 1'b0);
        chk("mid_rst_push", 32'(s_push), 32'h0);
        chk("mid_rst_occ", 32'(s_occ), 32'd0);
        chk("mid_rst_grant0", 32'(s_grant), 32'h1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 49) != 0), 4'($urandom), $urandom, 1'($urandom_range(0, 2) == 0 ? 0 : $urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data bits per entry.
REQ-002 Parameters SHALL be: NREQ, default 4, number of producers.
REQ-003 Parameters SHALL be: DEPTH, default 8, entries in the downstream shift-register FIFO.
REQ-004 Parameters SHALL be: CNTWID, default $clog2(DEPTH+1), occupancy counter width.
REQ-005 Port clk SHALL be: input, 1, the single clock; all state updates on posedge.
REQ-006 Port rst SHALL be: input, 1, synchronous, active-low reset.
REQ-007 Port req SHALL be: input, NREQ, producer k has an entry to push.
REQ-008 Port req_data SHALL be: input, NREQ*WIDTH, producer k data in bits [k*WIDTH +: WIDTH].
REQ-009 Port grant SHALL be: output, NREQ, one-hot-or-zero, combinational; req[k]&grant[k] is a transfer.
REQ-010 Port pop_req SHALL be: input, 1, consumer wants to remove the head entry.
REQ-011 Port fifo_push SHALL be: output, 1, registered push strobe to the FIFO.
REQ-012 Port fifo_data SHALL be: output, WIDTH, registered data to the FIFO, valid with fifo_push.
REQ-013 Port fifo_pop SHALL be: output, 1, combinational pop strobe to the FIFO.
REQ-014 Port occupancy SHALL be: output, CNTWID, shadow count of FIFO entries.

Function
REQ-015 occupancy SHALL increment on an edge with fifo_push=1, fifo_pop=0; decrement with fifo_push=0, fifo_pop=1; hold otherwise.
REQ-016 fifo_pop SHALL equal pop_req & (occupancy != 0); pop_req while empty is dropped, no underflow.
REQ-017 occ_next = occupancy + fifo_push - fifo_pop, computed at CNTWID+1 bits; a grant SHALL be issued only when occ_next < DEPTH.
REQ-018 When grant is permitted and any req is high, exactly one grant bit SHALL assert, to the first requesting index scanning ptr, ptr+1, ..., wrapping modulo NREQ.
REQ-019 ptr SHALL be set to (k+1) mod NREQ on the edge after a transfer by k; unchanged when no transfer.
REQ-020 A transfer in cycle t SHALL produce fifo_push=1 and fifo_data=req_data[k] in cycle t+1 (1-cycle latency); fifo_push=0 in cycles with no prior transfer.
REQ-021 Back-to-back transfers (one per cycle, same or different producers) SHALL be supported at full rate while occ_next < DEPTH.
REQ-022 Simultaneous fifo_push and fifo_pop SHALL leave occupancy unchanged; a pop in cycle t frees space for a grant in the same cycle t.
REQ-023 occupancy SHALL never exceed DEPTH nor wrap below 0; grant SHALL be 0 whenever occ_next == DEPTH.
REQ-024 grant SHALL not depend on req of non-selected producers beyond priority order (no combinational loop through grant).

Reset
REQ-025 On an edge with rst=0: occupancy=0, ptr=0, fifo_push=0, fifo_data=0.
REQ-026 While rst=0, grant and fifo_pop SHALL be forced to 0; a transfer pending at reset assertion SHALL be discarded.
REQ-027 First grant after rst deasserts SHALL be possible in the first cycle with rst=1.

Structure
REQ-028 Default WIDTH/NREQ/DEPTH constants SHALL reside in a shared package/include used by the arbiter and the FIFO.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, ptr, enable; output one-hot grant).
REQ-030 The block SHALL drive an unmodified shift_register FIFO instance whose push/pop environment constraints it guarantees.

Verification
REQ-031 Reset: rst=0 3 cycles with req=4'b1111, pop_req=1 -> grant=0, fifo_pop=0, fifo_push=0, occupancy=0.
REQ-032 Fairness: req=4'b1111 held, pop_req=1 -> grants cycle 0001,0010,0100,1000,0001; occupancy stays at 1 or 0, never rising.
REQ-033 Fill: req=4'b0001, pop_req=0 -> 8 transfers, occupancy=8, grant=0 thereafter; data 0x01..0x08 emerges in order on pop.
REQ-034 Full with simultaneous pop: occupancy=8, pop_req=1, req=4'b0100 -> grant=4'b0100 same cycle; occupancy stays 8.
REQ-035 Empty pop: occupancy=0, pop_req=1 -> fifo_pop=0, occupancy=0.
REQ-036 Reset mid-stream: transfer in cycle t, rst=0 in cycle t+1 -> fifo_push=0 after that edge, occupancy=0, next grant to index 0.
